// File: rtl/noc_inst_mem_loader_if.sv
// Load-packet stream from the NoC local port plus the Avalon-MM write
// master that fills the instruction memory.
interface noc_inst_mem_loader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              in_valid;
  logic              in_ready;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;

  // Loader side: sinks flits, drives the memory bus.
  modport master (
    input  in_data, in_sop, in_eop, in_valid,
    output in_ready,
    output mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write
  );

  // Environment side: router local port and instruction memory.
  modport slave (
    output in_data, in_sop, in_eop, in_valid,
    input  in_ready,
    input  mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write
  );
endinterface

// File: rtl/noc_inst_mem_loader.sv
// Boot loader: takes a load packet off the NoC, writes its payload into the
// tile instruction memory, holds the CPU in reset meanwhile and reports status.
module noc_inst_mem_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter logic [7:0]  OPCODE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  noc_inst_mem_loader_if.master bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic [1:0]            load_status,
  output logic [ADDR_W:0]       words_written
);

  localparam logic [ADDR_W:0] WW_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      ST_OK    = 2'b00;
  localparam logic [1:0]      ST_OPC   = 2'b01;
  localparam logic [1:0]      ST_FRAME = 2'b10;
  localparam logic [1:0]      ST_CSUM  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_CHECK, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       cnt_q;
  logic [DATA_W-1:0] xor_q;
  logic [1:0]        status_q, status_d;

  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_writedata_q;

  logic              accept;
  logic              hdr_load;
  logic              wr_d;
  logic              pulse_d;
  logic [7:0]        hdr_opcode;
  logic [11:0]       hdr_count;
  logic [ADDR_W-1:0] hdr_addr;

  assign accept     = bus.in_valid && bus.in_ready;
  assign hdr_opcode = bus.in_data[31:24];
  assign hdr_addr   = ADDR_W'(bus.in_data[23:12]);
  assign hdr_count  = bus.in_data[11:0];

  assign bus.in_ready       = (state_q != S_DONE);
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_chipselect = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_writedata  = mem_writedata_q;
  assign bus.mem_byteenable = 4'hF;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, write strobe, header capture and completion pulse.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    hdr_load = 1'b0;
    wr_d     = 1'b0;
    pulse_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && bus.in_sop) begin
          if (hdr_opcode != OPCODE) begin
            status_d = ST_OPC;
            pulse_d  = 1'b1;
            state_d  = bus.in_eop ? S_IDLE : S_DRAIN;
          end else begin
            hdr_load = 1'b1;
            if (bus.in_eop) begin
              status_d = ST_FRAME;
              state_d  = S_DONE;
            end else if (hdr_count == '0) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // A flit carrying sop belongs to some other packet, so it is not written.
          wr_d = !bus.in_sop;
          if (bus.in_sop || bus.in_eop) begin
            status_d = ST_FRAME;
            state_d  = bus.in_eop ? S_DONE : S_DRAIN;
          end else if (cnt_q == 12'd1) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (bus.in_eop) begin
            status_d = (bus.in_data != xor_q) ? ST_CSUM : ST_OK;
            state_d  = S_DONE;
          end else begin
            status_d = ST_FRAME;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (accept && bus.in_eop) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // cpu_hold marks an opcode-matched load; a drained bad-opcode packet
    // already pulsed at its header and passes through DONE silently.
    if (state_d == S_DONE && (cpu_hold || hdr_load)) pulse_d = 1'b1;
  end

  // Datapath: memory write port, address/count/checksum tracking, status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q          <= '0;
      cnt_q           <= '0;
      xor_q           <= '0;
      status_q        <= ST_OK;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      cpu_hold        <= 1'b0;
      load_done       <= 1'b0;
      load_status     <= ST_OK;
      words_written   <= '0;
    end else begin
      mem_write_q <= wr_d;
      load_done   <= pulse_d;
      status_q    <= status_d;
      if (pulse_d) load_status <= status_d;
      if (wr_d) begin
        mem_address_q   <= addr_q;
        mem_writedata_q <= bus.in_data;
        addr_q          <= addr_q + ADDR_W'(1);
        cnt_q           <= cnt_q - 12'd1;
        xor_q           <= xor_q ^ bus.in_data;
        if (words_written != WW_MAX) words_written <= words_written + (ADDR_W+1)'(1);
      end
      if (hdr_load) begin
        addr_q        <= hdr_addr;
        cnt_q         <= hdr_count;
        xor_q         <= '0;
        words_written <= '0;
        cpu_hold      <= 1'b1;
      end
      if (state_q == S_DONE) cpu_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_inst_mem_loader.sv
// Randomized packet bench for noc_inst_mem_loader with a packet-level model.
module tb_noc_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_hold;
  logic        load_done;
  logic [1:0]  load_status;
  logic [12:0] words_written;

  noc_inst_mem_loader_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  noc_inst_mem_loader #(.ADDR_W(12), .DATA_W(32), .OPCODE(8'hA5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_status   (load_status),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] addr; logic [31:0] data; int unsigned fidx; } wr_t;
  typedef struct { logic [1:0] st; logic [12:0] ww; int unsigned fidx; bit matched; } dn_t;

  wr_t         exp_wr[$];
  dn_t         exp_dn[$];
  logic [31:0] fd[$];
  bit          fs[$];
  bit          fe[$];
  int unsigned acc_cyc[64];
  logic [12:0] ww_model    = '0;
  logic [1:0]  held_status = '0;
  bit          chk_en      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pkt_clear();
    fd.delete(); fs.delete(); fe.delete();
  endtask

  task automatic add(input logic [31:0] d, input bit s, input bit e);
    fd.push_back(d); fs.push_back(s); fe.push_back(e);
  endtask

  // Expected outcome of the packet in fd/fs/fe, straight from the packet rules.
  function automatic void build_expect();
    logic [31:0] h;
    logic [31:0] x = '0;
    int unsigned a, n, nw = 0, last;
    logic [1:0]  st;
    bit          cut = 1'b0;
    h    = fd[0];
    last = fd.size() - 1;
    if (h[31:24] != 8'hA5) begin
      exp_dn.push_back('{st:2'b01, ww:ww_model, fidx:0, matched:1'b0});
      return;
    end
    a = h[23:12];
    n = h[11:0];
    for (int unsigned k = 0; k < n && !cut; k++) begin
      int unsigned i;
      i = 1 + k;
      if (!fs[i]) begin
        exp_wr.push_back('{addr:12'((a + k) % 4096), data:fd[i], fidx:i});
        nw++;
        x ^= fd[i];
      end
      if (fs[i] || fe[i]) cut = 1'b1;
    end
    if (cut)              st = 2'b10;
    else if (!fe[1 + n])  st = 2'b10;
    else                  st = (fd[1 + n] == x) ? 2'b00 : 2'b11;
    ww_model = 13'(nw);
    exp_dn.push_back('{st:st, ww:ww_model, fidx:last, matched:1'b1});
  endfunction

  // Per-cycle comparison of DUT outputs against the model queues.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (chk_en) begin
      if (bus.mem_write) begin
        if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", bus.mem_address, w.addr);
          check("wr_data", bus.mem_writedata, w.data);
          check("wr_cycle", cyc, acc_cyc[w.fidx]);
          check("wr_chipselect", bus.mem_chipselect, 1);
          check("wr_cpu_hold", cpu_hold, 1);
        end
      end else begin
        check("chipselect_idle", bus.mem_chipselect, 0);
      end
      check("byteenable", bus.mem_byteenable, 4'hF);
      if (load_done) begin
        if (exp_dn.size() == 0) check("unexpected_done", 1, 0);
        else begin
          d = exp_dn.pop_front();
          check("done_status", load_status, d.st);
          check("done_words", words_written, d.ww);
          check("done_cycle", cyc, acc_cyc[d.fidx]);
          check("done_in_ready", bus.in_ready, !d.matched);
          check("done_cpu_hold", cpu_hold, d.matched);
          held_status = d.st;
        end
      end else begin
        check("status_held", load_status, held_status);
      end
    end
  end

  // Called at negedge+1; returns at negedge+1 after the flit is taken.
  task automatic send_flit(input logic [31:0] d, input bit s, input bit e, input int unsigned idx);
    bit sent = 1'b0;
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_valid = 1'b1;
    for (int w = 0; w < 16 && !sent; w++) begin
      if (bus.in_ready) begin
        acc_cyc[idx] = cyc + 1;
        sent = 1'b1;
      end
      @(negedge clk); #1;
    end
    if (!sent) check("flit_accept_timeout", 0, 1);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic drive_packet();
    for (int i = 0; i < fd.size(); i++) send_flit(fd[i], fs[i], fe[i], i);
    idle_inputs();
    for (int w = 0; w < 12 && (exp_dn.size() != 0 || exp_wr.size() != 0); w++) begin
      @(negedge clk); #1;
    end
    check("packet_complete", exp_dn.size() + exp_wr.size(), 0);
    @(negedge clk); #1;
    check("idle_cpu_hold", cpu_hold, 0);
    check("idle_in_ready", bus.in_ready, 1);
  endtask

  task automatic gen_random();
    int unsigned kind = $urandom_range(0, 6);
    int unsigned n    = (kind == 6) ? 0 : $urandom_range(1, 12);
    logic [11:0] a;
    logic [7:0]  op = 8'hA5;
    logic [31:0] x  = '0;
    logic [31:0] v;
    int unsigned cut = 0;
    a = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7)) : 12'($urandom);
    pkt_clear();
    if (kind == 3) begin
      op = 8'($urandom);
      if (op == 8'hA5) op = 8'h5A;
      cut = $urandom_range(0, 5);
      add({op, a, 12'(n)}, 1'b1, cut == 0);
      for (int unsigned i = 1; i <= cut; i++) add($urandom, 1'b0, i == cut);
      return;
    end
    add({op, a, 12'(n)}, 1'b1, 1'b0);
    if (n > 0) cut = $urandom_range(0, n - 1);
    for (int unsigned i = 0; i < n; i++) begin
      v = $urandom;
      if (kind == 2 && i == cut) begin add(v, 1'b0, 1'b1); return; end
      if (kind == 5 && i == cut) begin
        add(v, 1'b1, 1'b0); add($urandom, 1'b0, 1'b0); add($urandom, 1'b0, 1'b1);
        return;
      end
      add(v, 1'b0, 1'b0);
      x ^= v;
    end
    case (kind)
      1:       add(x ^ (32'h1 << $urandom_range(0, 31)), 1'b0, 1'b1);
      4:       begin add(x, 1'b0, 1'b0); add($urandom, 1'b0, 1'b0); add($urandom, 1'b0, 1'b1); end
      default: add(x, 1'b0, 1'b1);
    endcase
  endtask

  task automatic load_t1();
    pkt_clear();
    add(32'hA5010003, 1'b1, 1'b0);
    add(32'd1, 1'b0, 1'b0); add(32'd2, 1'b0, 1'b0); add(32'd3, 1'b0, 1'b0);
    add(32'd0, 1'b0, 1'b1);
    build_expect();
  endtask

  initial begin
    logic [31:0] x;
    bus.in_data = '0;
    idle_inputs();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_chipselect", bus.mem_chipselect, 0);
    check("rst_address", bus.mem_address, 0);
    check("rst_writedata", bus.mem_writedata, 0);
    check("rst_byteenable", bus.mem_byteenable, 4'hF);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_status", load_status, 0);
    check("rst_words", words_written, 0);
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk_en = 1'b1;

    // T1: basic load
    load_t1();
    check("t1_model_nwr", exp_wr.size(), 3);
    check("t1_model_addr0", exp_wr[0].addr, 12'h010);
    check("t1_model_addr2", exp_wr[2].addr, 12'h012);
    check("t1_model_data2", exp_wr[2].data, 3);
    check("t1_model_status", exp_dn[0].st, 2'b00);
    drive_packet();
    check("t1_status", load_status, 2'b00);
    check("t1_words", words_written, 3);

    // T2: address wrap
    pkt_clear();
    add(32'hA5FFE004, 1'b1, 1'b0);
    x = '0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      x ^= v;
      add(v, 1'b0, 1'b0);
    end
    add(x, 1'b0, 1'b1);
    build_expect();
    check("t2_model_addr0", exp_wr[0].addr, 12'hFFE);
    check("t2_model_addr1", exp_wr[1].addr, 12'hFFF);
    check("t2_model_addr2", exp_wr[2].addr, 12'h000);
    check("t2_model_addr3", exp_wr[3].addr, 12'h001);
    drive_packet();
    check("t2_status", load_status, 2'b00);
    check("t2_words", words_written, 4);

    // T3: checksum error
    pkt_clear();
    add(32'hA5020003, 1'b1, 1'b0);
    add(32'd1, 1'b0, 1'b0); add(32'd2, 1'b0, 1'b0); add(32'd3, 1'b0, 1'b0);
    add(32'hDEADBEEF, 1'b0, 1'b1);
    build_expect();
    check("t3_model_status", exp_dn[0].st, 2'b11);
    drive_packet();
    check("t3_status", load_status, 2'b11);
    check("t3_words", words_written, 3);

    // T4: early eop, then a normal load
    pkt_clear();
    add(32'hA5030005, 1'b1, 1'b0);
    add(32'h0000AAAA, 1'b0, 1'b0); add(32'h0000BBBB, 1'b0, 1'b1);
    build_expect();
    check("t4_model_nwr", exp_wr.size(), 2);
    check("t4_model_status", exp_dn[0].st, 2'b10);
    drive_packet();
    check("t4_status", load_status, 2'b10);
    check("t4_words", words_written, 2);
    load_t1();
    drive_packet();
    check("t4_next_status", load_status, 2'b00);

    // T5: bad opcode, drained
    pkt_clear();
    add(32'h11234005, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add($urandom, 1'b0, 1'b0);
    add($urandom, 1'b0, 1'b1);
    build_expect();
    check("t5_model_nwr", exp_wr.size(), 0);
    check("t5_model_status", exp_dn[0].st, 2'b01);
    check("t5_model_words", exp_dn[0].ww, 3);
    drive_packet();
    check("t5_status", load_status, 2'b01);
    check("t5_words", words_written, 3);

    // Randomized packets with junk flits and idle gaps in between
    for (int p = 0; p < 200; p++) begin
      int unsigned nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) send_flit($urandom, 1'b0, 1'($urandom_range(0, 1)), 63);
      idle_inputs();
      repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
      gen_random();
      build_expect();
      drive_packet();
    end

    // T6: reset in the middle of DATA with in_valid held high
    pkt_clear();
    add(32'hA5100008, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) add(32'h1000 + i, 1'b0, 1'b0);
    add(32'h0, 1'b0, 1'b1);
    build_expect();
    for (int i = 0; i < 4; i++) send_flit(fd[i], fs[i], fe[i], i);
    check("t6_pre_reset_writes", exp_wr.size(), 5);
    bus.in_data  = fd[4];
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_valid = 1'b1;
    reset_n      = 1'b0;
    chk_en       = 1'b0;
    @(negedge clk); #1;
    check("t6_mem_write", bus.mem_write, 0);
    check("t6_cpu_hold", cpu_hold, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_load_done", load_done, 0);
    check("t6_words", words_written, 0);
    check("t6_status", load_status, 0);
    reset_n = 1'b1;
    idle_inputs();
    exp_wr.delete();
    exp_dn.delete();
    ww_model    = '0;
    held_status = '0;
    chk_en      = 1'b1;
    load_t1();
    drive_packet();
    check("t6_after_status", load_status, 2'b00);
    check("t6_after_words", words_written, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
